// File: rtl/bitty_fetch_sequencer_if.sv
// Bus between the fetch sequencer, the instruction memory, the bitty core and
// the branch logic. The sequencer is the master: it drives the fetch address,
// the latched instruction and the run pulse, and it receives read data, core
// completion and the branch-logic next PC.
interface bitty_fetch_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               core_run;
    logic               core_done;
    logic [ADDR_W-1:0]  next_pc;

    modport master (
        output mem_addr,
        output instr,
        output core_run,
        input  mem_rdata,
        input  core_done,
        input  next_pc
    );

    modport slave (
        input  mem_addr,
        input  instr,
        input  core_run,
        output mem_rdata,
        output core_done,
        output next_pc
    );
endinterface

// File: rtl/bitty_fetch_sequencer.sv
// Fetch/issue/commit sequencer for the bitty core. Each instruction is read
// from memory at pc, handed to the core with a one-cycle run pulse, and
// retired once the core reports done, at which point the branch-logic next PC
// becomes the new pc. Start/stop, single-step, an execute watchdog and a
// saturating retired-instruction count are provided.
//
// Memory timing: pc is held stable for the whole FETCH phase, and mem_rdata is
// captured on the MEM_LAT-th rising edge after the address is first presented.
module bitty_fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step_mode,
    input  logic                  clear_err,
    bitty_fetch_sequencer_if.master bus,
    output logic [ADDR_W-1:0]     pc,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [CNT_W-1:0]      retired
);

    localparam int FCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT);

    localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(MEM_LAT - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_COMMIT,
        S_FAULT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [FCNT_W-1:0]  fetch_cnt;
    logic [WCNT_W-1:0]  wait_cnt;
    logic               stop_latch;
    logic [INSTR_W-1:0] instr_q;
    logic               core_run;

    assign bus.mem_addr = pc;
    assign bus.instr    = instr_q;
    assign bus.core_run = core_run;

    // State register; a synchronous reset aborts any instruction in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the per-state status outputs.
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        core_run    = 1'b0;
        busy        = 1'b0;
        err_timeout = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (fetch_cnt == FETCH_LAST) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy       = 1'b1;
                core_run   = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                // done is checked first so it wins over a same-cycle timeout
                if (bus.core_done) begin
                    state_next = S_COMMIT;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_FAULT;
                end
            end
            S_COMMIT: begin
                busy = 1'b1;
                if (stop_latch || stop || step_mode) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_FAULT: begin
                err_timeout = 1'b1;
                if (clear_err) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: fetch/exec counters, instruction latch, pc, retired count and
    // the stop request that is only honoured at commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            instr_q    <= '0;
            retired    <= '0;
            fetch_cnt  <= '0;
            wait_cnt   <= '0;
            stop_latch <= 1'b0;
        end else begin
            if (state == S_FETCH) begin
                if (fetch_cnt == FETCH_LAST) begin
                    fetch_cnt <= '0;
                    instr_q   <= bus.mem_rdata;
                end else begin
                    fetch_cnt <= fetch_cnt + FCNT_W'(1);
                end
            end else begin
                fetch_cnt <= '0;
            end

            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_EXEC && !bus.core_done) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end

            if (state == S_COMMIT) begin
                // pc wraps only through next_pc; there is no internal increment
                pc <= bus.next_pc;
                if (!(&retired)) begin
                    retired <= retired + CNT_W'(1);
                end
            end

            if (state_next == S_IDLE) begin
                stop_latch <= 1'b0;
            end else if (busy && stop) begin
                stop_latch <= 1'b1;
            end
        end
    end

endmodule
